// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of one registered CDB between ALU and LSU skid FIFOs
module cdb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ROB_ID_W   = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   alu_target_pc,
  input  logic                alu_jump_result,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [ROB_ID_W-1:0] lsu_rob_id,
  input  logic [DATA_W-1:0]   lsu_result,
  output logic                cdb_valid,
  output logic                cdb_src,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value,
  output logic [DATA_W-1:0]   cdb_target_pc,
  output logic                cdb_jump_result
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int AE = ROB_ID_W + 2 * DATA_W + 1;
  localparam int LE = ROB_ID_W + DATA_W;
  typedef logic [AW:0] cnt_t;
  localparam cnt_t DEPTH = cnt_t'(FIFO_DEPTH);
  logic [AE-1:0] a_mem [FIFO_DEPTH];
  logic [LE-1:0] l_mem [FIFO_DEPTH];
  logic [AW-1:0] a_wp, a_rp, l_wp, l_rp;
  cnt_t a_cnt, l_cnt;
  logic rr;
  logic a_ne, l_ne, gnt_a, gnt_l, a_push, l_push, a_pop, l_pop, go;
  logic [AE-1:0] a_head;
  logic [LE-1:0] l_head;
  assign alu_ready = a_cnt < DEPTH;
  assign lsu_ready = l_cnt < DEPTH;
  assign go        = rdy & ~flush;
  assign a_push    = alu_valid & alu_ready & go & |alu_rob_id;
  assign l_push    = lsu_valid & lsu_ready & go & |lsu_rob_id;
  assign a_ne      = |a_cnt;
  assign l_ne      = |l_cnt;
  // rr = 1 means LSU wins the next tie; it only moves when both heads compete
  assign gnt_l     = l_ne & (~a_ne | rr);
  assign gnt_a     = a_ne & ~gnt_l;
  assign a_pop     = gnt_a & go;
  assign l_pop     = gnt_l & go;
  assign a_head    = a_mem[a_rp];
  assign l_head    = l_mem[l_rp];
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wp] <= {alu_rob_id, alu_result, alu_target_pc, alu_jump_result};
    if (l_push) l_mem[l_wp] <= {lsu_rob_id, lsu_result};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {a_wp, a_rp, l_wp, l_rp} <= '0;
      a_cnt <= '0;
      l_cnt <= '0;
      rr    <= 1'b0;
    end else if (rdy && flush) begin
      {a_wp, a_rp, l_wp, l_rp} <= '0;
      a_cnt <= '0;
      l_cnt <= '0;
    end else if (rdy) begin
      a_wp  <= a_push ? a_wp + 1'b1 : a_wp;
      a_rp  <= a_pop ? a_rp + 1'b1 : a_rp;
      l_wp  <= l_push ? l_wp + 1'b1 : l_wp;
      l_rp  <= l_pop ? l_rp + 1'b1 : l_rp;
      a_cnt <= a_cnt + cnt_t'(a_push) - cnt_t'(a_pop);
      l_cnt <= l_cnt + cnt_t'(l_push) - cnt_t'(l_pop);
      rr    <= (a_ne & l_ne) ? gnt_a : rr;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      {cdb_src, cdb_rob_id, cdb_value, cdb_target_pc, cdb_jump_result} <= '0;
    end else if (rdy) begin
      cdb_valid <= ~flush & (gnt_a | gnt_l);
      if (~flush & (gnt_a | gnt_l))
        {cdb_src, cdb_rob_id, cdb_value, cdb_target_pc, cdb_jump_result} <=
          gnt_a ? {1'b0, a_head} : {1'b1, l_head, {DATA_W{1'b0}}, 1'b0};
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus against a queue-based model of the CDB arbiter
module tb_cdb_arbiter;
  logic clk = 0, rst = 1, rdy = 1, flush = 0;
  logic alu_valid = 0, alu_jump_result = 0, lsu_valid = 0;
  logic [4:0] alu_rob_id = 0, lsu_rob_id = 0;
  logic [31:0] alu_result = 0, alu_target_pc = 0, lsu_result = 0;
  logic alu_ready, lsu_ready, cdb_valid, cdb_src, cdb_jump_result;
  logic [4:0] cdb_rob_id;
  logic [31:0] cdb_value, cdb_target_pc;
  int total = 0, bad = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_id(alu_rob_id),
    .alu_result(alu_result), .alu_target_pc(alu_target_pc), .alu_jump_result(alu_jump_result),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rob_id(lsu_rob_id), .lsu_result(lsu_result),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_target_pc(cdb_target_pc), .cdb_jump_result(cdb_jump_result)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] id; logic [31:0] val; logic [31:0] pc; logic jmp;} ent_t;
  ent_t aq[$], lq[$];
  bit m_rr;
  logic m_valid, m_src, m_jmp;
  logic [4:0] m_id;
  logic [31:0] m_val, m_pc;
  wire [73:0] obs = {alu_ready, lsu_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_target_pc, cdb_jump_result};

  function automatic logic [73:0] expv();
    return {aq.size() < 2, lq.size() < 2, m_valid, m_src, m_id, m_val, m_pc, m_jmp};
  endfunction

  task automatic model_reset();
    aq.delete(); lq.delete();
    m_rr = 0; {m_valid, m_src, m_id, m_val, m_pc, m_jmp} = '0;
  endtask

  // Applies one rising edge worth of behaviour to the model, using the inputs now on the pins.
  task automatic model_step();
    ent_t e;
    bit ao, lo, ga, gl;
    if (!rdy) return;
    if (flush) begin
      aq.delete(); lq.delete(); m_valid = 0;
      return;
    end
    ao = aq.size() < 2;
    lo = lq.size() < 2;
    ga = aq.size() != 0 && (lq.size() == 0 || !m_rr);
    gl = lq.size() != 0 && !ga;
    if (aq.size() != 0 && lq.size() != 0) m_rr = ga;
    m_valid = ga || gl;
    if (ga) begin
      e = aq.pop_front(); m_src = 0;
      {m_id, m_val, m_pc, m_jmp} = e;
    end else if (gl) begin
      e = lq.pop_front(); m_src = 1;
      {m_id, m_val, m_pc, m_jmp} = e;
    end
    if (alu_valid && ao && alu_rob_id != 0) aq.push_back({alu_rob_id, alu_result, alu_target_pc, alu_jump_result});
    if (lsu_valid && lo && lsu_rob_id != 0) lq.push_back({lsu_rob_id, lsu_result, 32'h0, 1'b0});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input logic [4:0] aid, input bit lv, input logic [4:0] lid);
    @(negedge clk);
    alu_valid = av; alu_rob_id = aid; alu_result = $urandom; alu_target_pc = $urandom;
    alu_jump_result = 1'($urandom);
    lsu_valid = lv; lsu_rob_id = lid; lsu_result = $urandom;
  endtask

  task automatic test_reset();
    rst = 1; #2 rst = 0; model_reset(); #1;
    total++;
    if (obs !== expv()) begin bad++; $display("FAIL reset got=%h exp=%h", obs, expv()); end
    @(negedge clk); rst = 1;
    tick();
    total++;
    if (obs !== expv()) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, expv()); end
  endtask

  task automatic test_single_alu();
    drive(1, 5'd3, 0, 0); alu_result = 32'h11;
    tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL single_alu cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_same_edge();
    drive(1, 5'd1, 1, 5'd2);
    tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL same_edge cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(1, 5'(i + 1), 1, 5'(i + 17)); else drive(0, 0, 0, 0);
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL alternate cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_lsu_full();
    drive(1, 5'd4, 1, 5'd5); tick();
    drive(0, 0, 1, 5'd6); tick();
    drive(0, 0, 1, 5'd7); rdy = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin @(negedge clk); rdy = 1; end
      if (i == 6) drive(0, 0, 0, 0);
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL lsu_full cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drive(1, 5'(8 + i), 1, 5'(20 + i)); tick(); end
    drive(0, 0, 0, 0); flush = 1;
    tick();
    @(negedge clk); flush = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL flush cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), 5'($urandom_range(0, 31)));
      rdy = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 19) == 0;
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
    @(negedge clk); rdy = 1; flush = 0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin drive(1, 5'(i + 1), 1, 5'(i + 9)); tick(); end
    #2 rst = 0; model_reset(); #1;
    total++;
    if (obs !== expv()) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs, expv()); end
    drive(0, 0, 0, 0); rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_alu();
    test_same_edge();
    test_alternate();
    test_lsu_full();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
